// File: rtl/arb_rr8_cache_sched.sv
// Eight-way round-robin arbiter feeding a single-entry registered output stage.
// Optional per-requester saturating grant counters when ARB_GRANT_CNT_EN is defined.
module arb_rr8_cache_sched #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                i_valid,
    input  logic [8*DATA_WIDTH-1:0]   i_data,
    output logic [7:0]                o_ready,
    output logic                      o_valid,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic [2:0]                o_src,
    input  logic                      i_ready
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [8*16-1:0]           o_grant_cnt
`endif
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e                state_q;
    logic [2:0]            rr_ptr_q;
    logic                  load;
    logic                  grant_any;
    logic                  grant;
    logic [2:0]            grant_idx;
    logic [DATA_WIDTH-1:0] sel_data;

    // Rotating priority search: first valid bit at or above rr_ptr, wrapping 7->0.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr_q;
        for (int i = 0; i < 8; i++) begin
            if (!grant_any && i_valid[rr_ptr_q + 3'(i)]) begin
                grant_any = 1'b1;
                grant_idx = rr_ptr_q + 3'(i);
            end
        end
    end

    always_comb begin
        load  = (state_q == StEmpty) | i_ready;
        grant = load & grant_any & ~rst;
        if (grant) begin
            o_ready = 8'h01 << grant_idx;
        end else begin
            o_ready = 8'h00;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (grant_idx == 3'(k)) begin
                sel_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StEmpty;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_src    <= 3'd0;
            rr_ptr_q <= 3'd0;
        end else if (grant) begin
            state_q  <= StFull;
            o_valid  <= 1'b1;
            o_data   <= sel_data;
            o_src    <= grant_idx;
            rr_ptr_q <= grant_idx + 3'd1;
        end else if (i_ready) begin
            // Downstream drained the beat and nothing replaced it.
            state_q <= StEmpty;
            o_valid <= 1'b0;
        end
    end

`ifdef ARB_GRANT_CNT_EN
    logic [15:0] cnt_q [8];

    for (genvar k = 0; k < 8; k++) begin : g_cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q[k] <= 16'h0000;
            end else if (grant && (grant_idx == 3'(k)) && (cnt_q[k] != 16'hFFFF)) begin
                cnt_q[k] <= cnt_q[k] + 16'h0001;
            end
        end
        assign o_grant_cnt[k*16 +: 16] = cnt_q[k];
    end
`endif

endmodule

// File: doc/arb_rr8_cache_sched.md
ARB_RR8_CACHE_SCHED -- requirements
Module: arb_rr8_cache_sched

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, payload width per requester.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: i_valid  input  8  per-requester request; bit k = requester k.
REQ-005 SHALL have port: i_data  input  8*DATA_WIDTH  requester k payload in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have port: o_ready  output  8  one-hot-or-zero accept; requester k transfers when i_valid[k] & o_ready[k].
REQ-007 SHALL have port: o_valid  output  1  output register holds a beat.
REQ-008 SHALL have port: o_data  output  DATA_WIDTH  granted payload.
REQ-009 SHALL have port: o_src  output  3  index of the requester that sourced o_data.
REQ-010 SHALL have port: i_ready  input  1  downstream accept; a beat transfers when o_valid & i_ready.
REQ-011 SHALL have port, only when ARB_GRANT_CNT_EN is defined: o_grant_cnt  output  8*16  per-requester grant counters; counter k in bits [k*16 +: 16].

Function
REQ-012 SHALL implement a two-state output FSM: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-013 SHALL define load = (state==EMPTY) | i_ready; arbitration occurs only when load=1.
REQ-014 SHALL select, when load=1 and i_valid!=0, exactly one requester: the first asserted i_valid bit searching upward from rr_ptr, wrapping 7->0.
REQ-015 SHALL drive o_ready as the one-hot selected bit when load=1 and i_valid!=0, else 8'h00; o_ready is combinational from i_valid, i_ready, state and rr_ptr.
REQ-016 SHALL require requesters not to make i_valid depend combinationally on o_ready.
REQ-017 SHALL, on a grant to requester k, capture i_data slice k into o_data, k into o_src, and set rr_ptr to (k+1) mod 8 on the same clock edge.
REQ-018 SHALL give a latency of exactly 1 cycle from the accept edge to o_valid=1 with the captured beat.
REQ-019 SHALL sustain one beat per cycle when i_ready=1 continuously and any i_valid is set.
REQ-020 SHALL transition EMPTY->FULL on a grant; FULL->EMPTY when i_ready=1 and no grant; FULL->FULL when i_ready=1 with a grant (back-to-back) or when i_ready=0.
REQ-021 SHALL hold o_valid, o_data, o_src and rr_ptr stable while FULL and i_ready=0.
REQ-022 SHALL leave rr_ptr unchanged in any cycle without a grant.
REQ-023 SHALL, with all 8 requesters continuously valid, grant in order rr_ptr, rr_ptr+1, ... so each requester waits at most 7 grants.
REQ-024 SHALL ignore i_data of non-selected requesters; o_data is don't-care-free (holds last beat) when EMPTY.

Reset
REQ-025 SHALL, while rst=1, asynchronously force state=EMPTY, o_valid=0, o_data=0, o_src=0, rr_ptr=0, o_ready=8'h00, and all grant counters to 0.
REQ-026 SHALL discard any beat held in the output register when rst asserts mid-operation; no transfer completes in a cycle where rst=1.
REQ-027 SHALL resume arbitration on the first rising clk edge after rst deasserts, starting from requester 0.

Configuration
REQ-028 SHALL, with macro ARB_GRANT_CNT_EN defined, instantiate eight 16-bit counters, counter k incrementing by 1 on each grant to requester k and saturating at 16'hFFFF.
REQ-029 SHALL, without ARB_GRANT_CNT_EN, omit o_grant_cnt and all counter logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: reset release, i_valid=8'h01, i_data slice0=8'hA5, i_ready=1 -> o_ready=8'h01 in cycle 0, o_valid=1, o_data=8'hA5, o_src=0 in cycle 1, o_valid=0 in cycle 2.
REQ-031 SHALL cover: i_valid=8'hFF held, i_ready=1 -> o_src sequence 0,1,2,...,7,0 on consecutive cycles, o_valid=1 throughout.
REQ-032 SHALL cover: FULL with o_src=3, i_ready=0 for 5 cycles, i_valid=8'hFF -> o_ready=8'h00, o_data/o_src unchanged for 5 cycles; i_ready=1 then grants requester 4.
REQ-033 SHALL cover: rr_ptr=6, i_valid=8'h21 -> grant requester 0 (wrap), then next grant requester 5, rr_ptr=6.
REQ-034 SHALL cover: rst pulsed while FULL with o_src=5 -> o_valid=0 immediately, next grant with i_valid=8'hFF is requester 0.
REQ-035 SHALL cover, with ARB_GRANT_CNT_EN: 70000 grants to requester 2 -> counter 2 = 16'hFFFF, all other counters = 0.
